// File: rtl/nco_bpsk_gen_pkg.sv
// Shared defaults, quadrant encoding and ROM content generator for the BPSK carrier NCO.
// The ROM table is computed at elaboration time, so no external memory image is needed.
package nco_bpsk_gen_pkg;

  localparam int PHASE_W_DEF = 32;
  localparam int LUT_AW_DEF  = 10;
  localparam int OUT_W_DEF   = 16;

  localparam real PI = 3.14159265358979323846;

  // Quadrant of the full wave, named by the sine's slope and sign in that quadrant.
  typedef enum logic [1:0] {
    Q_RISE_POS = 2'd0,
    Q_FALL_POS = 2'd1,
    Q_FALL_NEG = 2'd2,
    Q_RISE_NEG = 2'd3
  } quad_e;

  // round(amp * sin(2*pi*(idx+0.5)/2^(aw+2))); angle stays within [0, pi/2] so a short series is exact enough.
  function automatic int rom_value(input int idx, input int aw, input int ow);
    real x;
    real term;
    real sum;
    real amp;
    x    = 2.0 * PI * (real'(idx) + 0.5) / real'(2 ** (aw + 2));
    term = x;
    sum  = x;
    for (int n = 1; n < 12; n++) begin
      term = -term * x * x / real'((2 * n) * (2 * n + 1));
      sum  = sum + term;
    end
    amp = real'((2 ** (ow - 1)) - 1);
    return int'(amp * sum);
  endfunction

endpackage

// File: rtl/nco_quarter_rom.sv
// Dual-read quarter-wave sine ROM with registered outputs.
// Contents are generated from the package function at elaboration.
module nco_quarter_rom
  import nco_bpsk_gen_pkg::*;
#(
  parameter int LUT_AW = LUT_AW_DEF,
  parameter int OUT_W  = OUT_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [LUT_AW-1:0]        addr_a,
  input  logic [LUT_AW-1:0]        addr_b,
  output logic signed [OUT_W-1:0]  data_a,
  output logic signed [OUT_W-1:0]  data_b
);

  localparam int DEPTH = 1 << LUT_AW;

  logic signed [OUT_W-1:0] rom_tbl [DEPTH];

  for (genvar i = 0; i < DEPTH; i++) begin : g_tbl
    localparam logic signed [OUT_W-1:0] VAL = OUT_W'(rom_value(i, LUT_AW, OUT_W));
    assign rom_tbl[i] = VAL;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_a <= '0;
      data_b <= '0;
    end else if (en) begin
      data_a <= rom_tbl[addr_a];
      data_b <= rom_tbl[addr_b];
    end
  end

endmodule

// File: rtl/nco_bpsk_gen.sv
// Phase-accumulator NCO with quarter-wave ROM, programmable step/offset and per-sample BPSK flip.
// Four-stage pipeline with a valid/ready output that stalls the whole datapath on backpressure.
module nco_bpsk_gen
  import nco_bpsk_gen_pkg::*;
#(
  parameter int PHASE_W = PHASE_W_DEF,
  parameter int LUT_AW  = LUT_AW_DEF,
  parameter int OUT_W   = OUT_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     cfg_valid,
  output logic                     cfg_ready,
  input  logic [PHASE_W-1:0]       cfg_ftw,
  input  logic [PHASE_W-1:0]       cfg_poff,
  input  logic                     phase_clr,
  input  logic                     bpsk_flip,
  output logic                     sine_rdy,
  input  logic                     sine_ack,
  output logic signed [OUT_W-1:0]  sine_out,
  output logic signed [OUT_W-1:0]  cos_out
);

  // Only the top quadrant+address bits of the phase reach the ROM; lower bits are truncated at S0.
  localparam int TOP_W = LUT_AW + 2;
  localparam logic [PHASE_W-1:0] HALF        = PHASE_W'(1) << (PHASE_W - 1);
  localparam logic [TOP_W-1:0]   QUARTER_TOP = TOP_W'(1) << LUT_AW;

  function automatic logic [LUT_AW-1:0] fold_addr(input quad_e q, input logic [LUT_AW-1:0] a);
    return (q inside {Q_FALL_POS, Q_RISE_NEG}) ? ~a : a;
  endfunction

  function automatic logic is_neg(input quad_e q);
    return q inside {Q_FALL_NEG, Q_RISE_NEG};
  endfunction

  function automatic logic signed [OUT_W-1:0] apply_sign(input logic signed [OUT_W-1:0] v,
                                                         input logic neg);
    return neg ? -v : v;
  endfunction

  logic adv;
  logic [PHASE_W-1:0] acc;
  logic [PHASE_W-1:0] ftw;
  logic [PHASE_W-1:0] poff;

  logic [TOP_W-1:0]  ph_p0;
  logic              vld_p0;
  logic [LUT_AW-1:0] addr_s_p1, addr_c_p1;
  logic              neg_s_p1, neg_c_p1, vld_p1;
  logic              neg_s_p2, neg_c_p2, vld_p2;
  logic signed [OUT_W-1:0] rom_s_p2, rom_c_p2;

  logic [TOP_W-1:0] ph_cos;
  quad_e            q_s, q_c;

  assign adv = en & (~sine_rdy | sine_ack);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cfg_ready <= 1'b0;
      ftw       <= '0;
      poff      <= '0;
    end else begin
      cfg_ready <= 1'b1;
      if (cfg_valid && cfg_ready) begin
        ftw  <= cfg_ftw;
        poff <= cfg_poff;
      end
    end
  end

  // S0: accumulate and capture this sample's phase (old acc + offset + optional half turn)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc    <= '0;
      ph_p0  <= '0;
      vld_p0 <= 1'b0;
    end else if (adv) begin
      acc    <= phase_clr ? '0 : acc + ftw;
      ph_p0  <= TOP_W'((acc + poff + (bpsk_flip ? HALF : '0)) >> (PHASE_W - TOP_W));
      vld_p0 <= 1'b1;
    end
  end

  assign ph_cos = ph_p0 + QUARTER_TOP;
  assign q_s    = quad_e'(ph_p0[TOP_W-1 -: 2]);
  assign q_c    = quad_e'(ph_cos[TOP_W-1 -: 2]);

  // S1: fold phases onto the quarter wave, remember which outputs need negating
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_s_p1 <= '0;
      addr_c_p1 <= '0;
      neg_s_p1  <= 1'b0;
      neg_c_p1  <= 1'b0;
      vld_p1    <= 1'b0;
    end else if (adv) begin
      addr_s_p1 <= fold_addr(q_s, ph_p0[LUT_AW-1:0]);
      addr_c_p1 <= fold_addr(q_c, ph_cos[LUT_AW-1:0]);
      neg_s_p1  <= is_neg(q_s);
      neg_c_p1  <= is_neg(q_c);
      vld_p1    <= vld_p0;
    end
  end

  // S2: registered ROM lookup for both outputs
  nco_quarter_rom #(
    .LUT_AW (LUT_AW),
    .OUT_W  (OUT_W)
  ) u_rom (
    .clk    (clk),
    .rst    (rst),
    .en     (adv),
    .addr_a (addr_s_p1),
    .addr_b (addr_c_p1),
    .data_a (rom_s_p2),
    .data_b (rom_c_p2)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      neg_s_p2 <= 1'b0;
      neg_c_p2 <= 1'b0;
      vld_p2   <= 1'b0;
    end else if (adv) begin
      neg_s_p2 <= neg_s_p1;
      neg_c_p2 <= neg_c_p1;
      vld_p2   <= vld_p1;
    end
  end

  // S3: apply quadrant sign and present the samples
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sine_out <= '0;
      cos_out  <= '0;
      sine_rdy <= 1'b0;
    end else if (adv) begin
      sine_out <= apply_sign(rom_s_p2, neg_s_p2);
      cos_out  <= apply_sign(rom_c_p2, neg_c_p2);
      sine_rdy <= vld_p2;
    end
  end

endmodule

// File: tb/tb_nco_bpsk_gen.sv
// Scoreboard bench for nco_bpsk_gen: a phase-level reference model predicts every sample with $sin/$cos.
// Directed scenarios first, then randomized enable/backpressure/flip/clear/config traffic.
module tb_nco_bpsk_gen;

  localparam real PI = 3.14159265358979323846;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en = 1'b0;
  logic cfg_valid = 1'b0;
  logic cfg_ready;
  logic [31:0] cfg_ftw = '0;
  logic [31:0] cfg_poff = '0;
  logic phase_clr = 1'b0;
  logic bpsk_flip = 1'b0;
  logic sine_rdy;
  logic sine_ack = 1'b0;
  logic signed [15:0] sine_out;
  logic signed [15:0] cos_out;

  nco_bpsk_gen dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ftw   (cfg_ftw),
    .cfg_poff  (cfg_poff),
    .phase_clr (phase_clr),
    .bpsk_flip (bpsk_flip),
    .sine_rdy  (sine_rdy),
    .sine_ack  (sine_ack),
    .sine_out  (sine_out),
    .cos_out   (cos_out)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Ideal carrier: 4096-point full wave sampled at half-step offsets, rounded to nearest.
  function automatic int ref_wave(input logic [31:0] ph, input bit is_cos);
    real x;
    real v;
    int  k;
    k = int'(ph[31:20]);
    x = 2.0 * PI * (real'(k) + 0.5) / 4096.0;
    v = 32767.0 * (is_cos ? $cos(x) : $sin(x));
    return (v >= 0.0) ? int'($floor(v + 0.5)) : -int'($floor(-v + 0.5));
  endfunction

  typedef struct { int s; int c; } samp_t;
  samp_t expq[$];

  logic [31:0] acc_m = '0;
  logic [31:0] ftw_m = '0;
  logic [31:0] poff_m = '0;
  int advs = 0;
  int cyc = 0;

  // Monitor/model: evaluated at the falling edge, describing what the next rising edge does.
  always @(negedge clk) begin
    bit rdy_exp;
    samp_t e;
    logic [31:0] ph;
    if (!rst) begin
      check("rst_sine_rdy", sine_rdy, 0);
      check("rst_sine_out", sine_out, 0);
      check("rst_cos_out", cos_out, 0);
      check("rst_cfg_ready", cfg_ready, 0);
      acc_m = '0; ftw_m = '0; poff_m = '0;
      expq.delete();
      advs = 0; cyc = 0;
    end else begin
      rdy_exp = (advs >= 4);
      check("sine_rdy", sine_rdy, rdy_exp);
      check("cfg_ready", cfg_ready, (cyc >= 1));
      if (en && rdy_exp && sine_ack) begin
        if (expq.size() == 0) begin
          check("queue_nonempty", 0, 1);
        end else begin
          e = expq.pop_front();
          check("sine_out", sine_out, e.s);
          check("cos_out", cos_out, e.c);
        end
      end
      if (en && (!rdy_exp || sine_ack)) begin
        ph = acc_m + poff_m + (bpsk_flip ? 32'h8000_0000 : 32'h0);
        e.s = ref_wave(ph, 1'b0);
        e.c = ref_wave(ph, 1'b1);
        expq.push_back(e);
        acc_m = phase_clr ? 32'h0 : acc_m + ftw_m;
        advs++;
      end
      if (cfg_valid && cyc >= 1) begin
        ftw_m  = cfg_ftw;
        poff_m = cfg_poff;
      end
      cyc++;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic cfg_write(input logic [31:0] f, input logic [31:0] p);
    cfg_valid = 1'b1; cfg_ftw = f; cfg_poff = p;
    tick();
    cfg_valid = 1'b0;
  endtask

  initial begin
    tick(3);
    // Test 1: reset release with ftw=0 gives a steady 25 / 32767
    rst = 1'b1; en = 1'b1; sine_ack = 1'b1;
    tick(8);
    @(negedge clk);
    check("t1_sine_dc", sine_out, 25);
    check("t1_cos_dc", cos_out, 32767);
    tick();

    // Test 2: quarter-turn step
    cfg_write(32'h4000_0000, 32'h0);
    tick(12);

    // Test 3: single flipped sample
    bpsk_flip = 1'b1; tick(); bpsk_flip = 1'b0;
    tick(8);

    // Test 4: backpressure hold
    sine_ack = 1'b0; tick(5); sine_ack = 1'b1;
    tick(8);

    // Test 5: phase clear and mid-run step change
    cfg_write(32'h0100_0000, 32'h0);
    tick(4);
    phase_clr = 1'b1; tick(); phase_clr = 1'b0;
    tick(4);
    @(negedge clk);
    check("t5_clr_restart", sine_out, 25);
    tick(2);
    cfg_write(32'h0200_0000, 32'h0);
    tick(6);

    // Test 6: randomized traffic
    for (int i = 0; i < 3000; i++) begin
      en        = ($urandom_range(0, 9) != 0);
      sine_ack  = ($urandom_range(0, 3) != 0);
      bpsk_flip = $urandom_range(0, 1);
      phase_clr = ($urandom_range(0, 49) == 0);
      cfg_valid = ($urandom_range(0, 39) == 0);
      cfg_ftw   = $urandom();
      cfg_poff  = $urandom();
      tick();
    end
    cfg_valid = 1'b0; phase_clr = 1'b0; bpsk_flip = 1'b0;

    // Test 7: reset during streaming with en toggling, then recovery
    for (int i = 0; i < 10; i++) begin
      en = $urandom_range(0, 1); sine_ack = 1'b1;
      tick();
    end
    rst = 1'b0;
    @(negedge clk);
    check("t7_rst_rdy", sine_rdy, 0);
    check("t7_rst_sine", sine_out, 0);
    check("t7_rst_cos", cos_out, 0);
    tick(2);
    en = 1'b1; sine_ack = 1'b1;
    rst = 1'b1;
    tick(3);
    @(negedge clk);
    check("t7_rdy_low_3rd", sine_rdy, 0);
    tick();
    @(negedge clk);
    check("t7_rdy_4th", sine_rdy, 1);
    check("t7_sine", sine_out, 25);
    check("t7_cos", cos_out, 32767);
    tick(6);

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
